hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Forwarding/hazard controller driving the operand-select side of the execute-stage operand muxes.
//  Tracks destination registers of the two older in-flight instructions (EX, WB).
//  Per decode-stage instruction it produces the 2-bit operand selects, a load-use stall and a branch flush.
//  Keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  CNT_W   16  width of stall-cycle counter
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst            in   1   asynchronous, active-low reset
//  id_valid_i     in   1   decode-stage instruction valid
//  id_rs1_i       in   5   decode rs1 index
//  id_rs2_i       in   5   decode rs2 index
//  id_use_rs1_i   in   1   instruction reads rs1
//  id_use_rs2_i   in   1   instruction reads rs2 (incl. store data)
//  id_rd_i        in   5   decode rd index
//  id_wen_i       in   1   instruction writes rd
//  id_load_i      in   1   instruction is a load
//  br_taken_i     in   1   branch/jump resolved taken in EX this cycle
//  cnt_clr_i      in   1   synchronous clear of stall counter
//  A1_sel_o       out  2   rs1 select: 00 regfile, 01 alu (EX), 10 wb
//  B1_sel_o       out  2   rs2 select: same encoding
//  stall_o        out  1   hold PC/decode, inject bubble into EX
//  flush_o        out  1   squash decode instruction, inject bubble into EX
//  stall_cnt_o    out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  State: ex_{vld,rd,wen,load}, wb_{vld,rd,wen}; all 0 on reset; stall_cnt_o = 0 on reset.
//  Async reset: state clears immediately on rst low, mid-operation; outputs become 00/00/0/0 while low.
//  Selects/stall/flush are combinational from state + decode inputs (0-cycle latency).
//  ex_hit_x = ex_vld & ex_wen & ex_rd==rs_x & rs_x!=0 & use_x; wb_hit_x likewise on wb_*.
//  sel_x = ex_hit_x ? 01 : wb_hit_x ? 10 : 00 (EX has priority, youngest wins).
//  Register x0 is never forwarded; sel = 00 when use_x = 0 or id_valid_i = 0.
//  stall_o = id_valid_i & ~br_taken_i & ex_load & (ex_hit_1 | ex_hit_2).
//  flush_o = br_taken_i (flush overrides stall; killed instruction needs no stall).
//  Per posedge, WB always advances: wb_* <= ex_*.
//  EX load: if (stall_o | flush_o | ~id_valid_i) ex_vld<=0 (bubble) else ex_* <= id_*.
//  After a load-use stall the load sits in WB, so the held consumer gets sel = 10 next cycle.
//  Counter: cnt_clr_i -> 0 (priority); else +1 when stall_o, holding at 2^CNT_W-1.
//  No internal FSM beyond the 2-deep shadow pipeline; stall lasts exactly one cycle per load-use.
// TESTING
//  T1 reset: rst=0 mid-stream -> all outputs 0, stall_cnt_o=0 at once; first instr after release sel=00.
//  T2 back-to-back ALU: add x5 then sub x6,x5,x5 -> A1_sel=B1_sel=01; one cycle later dependent -> 10.
//  T3 load-use: lw x7 then add x8,x7,x1 -> stall_o=1 one cycle, next cycle A1_sel=10, B1_sel=00, cnt=1.
//  T4 x0/priority: writes to x0 never forward (sel=00); rd=x9 in both EX and WB -> sel=01.
//  T5 flush vs stall: lw x7 in EX, dependent in decode, br_taken_i=1 -> flush_o=1, stall_o=0, EX bubble.
//  T6 counter: force stall 2^CNT_W+3 cycles (CNT_W=4) -> saturates at 15; cnt_clr_i -> 0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding select, load-use stall and branch flush control for the execute operand muxes
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_wen_i,
  input  logic             id_load_i,
  input  logic             br_taken_i,
  input  logic             cnt_clr_i,
  output logic [1:0]       A1_sel_o,
  output logic [1:0]       B1_sel_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic       ex_vld, ex_wen, ex_load;
  logic [4:0] ex_rd;
  logic       wb_vld, wb_wen;
  logic [4:0] wb_rd;

  logic ex_hit_1, ex_hit_2, wb_hit_1, wb_hit_2;
  logic bubble;

  always_comb begin
    ex_hit_1 = id_valid_i & id_use_rs1_i & (id_rs1_i != 5'd0) & ex_vld & ex_wen & (ex_rd == id_rs1_i);
    ex_hit_2 = id_valid_i & id_use_rs2_i & (id_rs2_i != 5'd0) & ex_vld & ex_wen & (ex_rd == id_rs2_i);
    wb_hit_1 = id_valid_i & id_use_rs1_i & (id_rs1_i != 5'd0) & wb_vld & wb_wen & (wb_rd == id_rs1_i);
    wb_hit_2 = id_valid_i & id_use_rs2_i & (id_rs2_i != 5'd0) & wb_vld & wb_wen & (wb_rd == id_rs2_i);

    // The younger producer in EX wins over WB.
    A1_sel_o = ex_hit_1 ? 2'b01 : (wb_hit_1 ? 2'b10 : 2'b00);
    B1_sel_o = ex_hit_2 ? 2'b01 : (wb_hit_2 ? 2'b10 : 2'b00);

    // A taken branch kills the consumer, so it never needs to wait on the load.
    stall_o = rst & id_valid_i & ~br_taken_i & ex_load & (ex_hit_1 | ex_hit_2);
    flush_o = rst & br_taken_i;
    bubble  = stall_o | flush_o | ~id_valid_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_vld  <= 1'b0;
      ex_wen  <= 1'b0;
      ex_load <= 1'b0;
      ex_rd   <= 5'd0;
      wb_vld  <= 1'b0;
      wb_wen  <= 1'b0;
      wb_rd   <= 5'd0;
    end else begin
      wb_vld <= ex_vld;
      wb_wen <= ex_wen;
      wb_rd  <= ex_rd;
      if (bubble) begin
        ex_vld  <= 1'b0;
        ex_wen  <= 1'b0;
        ex_load <= 1'b0;
      end else begin
        ex_vld  <= 1'b1;
        ex_wen  <= id_wen_i;
        ex_load <= id_load_i;
        ex_rd   <= id_rd_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table, corner-case and randomized model checks for hazard_ctrl
module tb_hazard_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid_i;
  logic [4:0]       id_rs1_i, id_rs2_i, id_rd_i;
  logic             id_use_rs1_i, id_use_rs2_i, id_wen_i, id_load_i;
  logic             br_taken_i, cnt_clr_i;
  logic [1:0]       A1_sel_o, B1_sel_o;
  logic             stall_o, flush_o;
  logic [CNT_W-1:0] stall_cnt_o;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_rd_i(id_rd_i), .id_wen_i(id_wen_i), .id_load_i(id_load_i),
    .br_taken_i(br_taken_i), .cnt_clr_i(cnt_clr_i),
    .A1_sel_o(A1_sel_o), .B1_sel_o(B1_sel_o), .stall_o(stall_o), .flush_o(flush_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic load, input logic br, input logic clr);
    id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_use_rs1_i = u1; id_use_rs2_i = u2;
    id_rd_i = rd; id_wen_i = wen; id_load_i = load; br_taken_i = br; cnt_clr_i = clr;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                         input logic es, input logic ef, input int ec);
    chk({tag, "_A"}, 32'(A1_sel_o), 32'(ea));
    chk({tag, "_B"}, 32'(B1_sel_o), 32'(eb));
    chk({tag, "_stall"}, 32'(stall_o), 32'(es));
    chk({tag, "_flush"}, 32'(flush_o), 32'(ef));
    chk({tag, "_cnt"}, 32'(stall_cnt_o), ec);
  endtask

  typedef struct packed {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2; logic [4:0] rd;
    logic wen; logic load; logic br; logic clr;
    logic [1:0] ea; logic [1:0] eb; logic es; logic ef; logic [3:0] ec;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic wen, input logic load, input logic br, input logic clr,
                              input logic [1:0] ea, input logic [1:0] eb, input logic es,
                              input logic ef, input logic [3:0] ec);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
    t.wen = wen; t.load = load; t.br = br; t.clr = clr;
    t.ea = ea; t.eb = eb; t.es = es; t.ef = ef; t.ec = ec;
    return t;
  endfunction

  // Behavioural model: list of in-flight producers, youngest first.
  typedef struct packed { logic v; logic [4:0] rd; logic wen; logic load; } ent_t;
  ent_t pipe [2];
  int   mcnt;

  function automatic logic [1:0] m_sel(input logic v, input logic use_, input logic [4:0] rs);
    if (!v || !use_ || rs == 5'd0) return 2'b00;
    for (int a = 0; a < 2; a++)
      if (pipe[a].v && pipe[a].wen && pipe[a].rd == rs) return (a == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  vec_t tbl [15];

  initial begin
    logic [1:0] ea, eb;
    logic       es;
    tbl[0]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0,  1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 6, 5, 1, 1, 10, 1, 0, 0, 0, 1, 2, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 7, 1, 1, 1, 8, 1, 0, 0, 0,  1, 0, 1, 0, 0);
    tbl[5]  = mk(1, 7, 1, 1, 1, 8, 1, 0, 0, 0,  2, 0, 0, 0, 1);
    tbl[6]  = mk(1, 8, 0, 1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0,  0, 0, 0, 0, 1);
    tbl[8]  = mk(1, 9, 9, 0, 0, 9, 1, 0, 0, 0,  0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 9, 9, 1, 1, 11, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    tbl[10] = mk(1, 9, 0, 1, 0, 7, 1, 1, 0, 0,  2, 0, 0, 0, 1);
    tbl[11] = mk(1, 7, 7, 1, 1, 12, 1, 0, 1, 0, 1, 1, 0, 1, 1);
    tbl[12] = mk(1, 7, 12, 1, 1, 13, 1, 0, 0, 0, 2, 0, 0, 0, 1);
    tbl[13] = mk(0, 13, 13, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(1, 13, 0, 1, 0, 14, 1, 0, 0, 0, 2, 0, 0, 0, 1);

    rst = 1'b0;
    drive(1, 3, 3, 1, 1, 3, 1, 1, 1, 0);
    repeat (2) @(negedge clk);
    #1 chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
            tbl[i].wen, tbl[i].load, tbl[i].br, tbl[i].clr);
      #1 chk_all($sformatf("tbl%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].es, tbl[i].ef, int'(tbl[i].ec));
    end

    // Mid-stream asynchronous reset away from any clock edge.
    @(negedge clk);
    drive(1, 14, 0, 1, 0, 15, 1, 0, 1, 0);
    #1 chk("t1_pre_A", 32'(A1_sel_o), 32'd1);
    #1 rst = 1'b0;
    #1 chk_all("t1_in_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 14, 13, 1, 1, 15, 1, 0, 0, 0);
    #1 chk_all("t1_after", 0, 0, 0, 0, 0);

    // Counter saturation through repeated load-use pairs.
    for (int p = 0; p < (1 << CNT_W) + 3; p++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
      @(negedge clk);
      drive(1, 2, 7, 1, 1, 8, 1, 0, 0, 0);
      #1;
      if (p == 3) chk("t6_cnt3", 32'(stall_cnt_o), 32'd3);
      if (p == 0 || p == 17) chk($sformatf("t6_stall%0d", p), 32'(stall_o), 32'd1);
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("t6_sat", 32'(stall_cnt_o), 32'd15);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("t6_clr", 32'(stall_cnt_o), 32'd0);

    // Randomized run against the producer-list model, from a clean reset.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pipe[0] = '0; pipe[1] = '0; mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive(($urandom_range(7) != 0), 5'($urandom_range(7)), 5'($urandom_range(7)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(7)),
            ($urandom_range(3) != 0), ($urandom_range(2) == 0), ($urandom_range(7) == 0),
            ($urandom_range(31) == 0));
      ea = m_sel(id_valid_i, id_use_rs1_i, id_rs1_i);
      eb = m_sel(id_valid_i, id_use_rs2_i, id_rs2_i);
      es = id_valid_i && !br_taken_i && pipe[0].v && pipe[0].load && (ea == 2'b01 || eb == 2'b01);
      #1 chk_all($sformatf("rnd%0d", c), ea, eb, es, br_taken_i, mcnt);
      pipe[1] = pipe[0];
      if (es || br_taken_i || !id_valid_i) pipe[0] = '0;
      else pipe[0] = '{v: 1'b1, rd: id_rd_i, wen: id_wen_i, load: id_load_i};
      if (cnt_clr_i) mcnt = 0;
      else if (es && mcnt < (1 << CNT_W) - 1) mcnt++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
